// File: rtl/dac_pkg.sv
// Shared definitions for the DAC serializer: FSM encoding, default geometry
// and a width helper for counters that must stay at least one bit wide.
package dac_pkg;

  localparam int DAC_DATA_W     = 16;
  localparam int DAC_CLK_DIV    = 2;
  localparam int DAC_GAP_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dac_bit_timer.sv
// SCLK half-period divider. The tick marks the last clk cycle of a half period.
// The phase output is 0 during the SCLK-low half and 1 during the SCLK-high half.
module dac_bit_timer
  import dac_pkg::*;
#(
  parameter int CLK_DIV = DAC_CLK_DIV
) (
  input  logic   clk,
  input  logic   reset,
  input  state_t state,
  output logic   tick,
  output logic   phase
);

  localparam int DIV_W = cnt_width(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             run;

  assign run  = (state == SHIFT);
  assign tick = run && (div_cnt == DIV_LAST);

  // Held at zero outside SHIFT so each frame starts on a fresh low half.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      phase   <= ~phase;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dac_serializer.sv
// One-sample buffered parallel-to-serial DAC driver, SPI mode 0, MSB first.
// Holding register, shift register, bit/gap counters, FSM and registered pins.
module dac_serializer
  import dac_pkg::*;
#(
  parameter int DATA_W     = DAC_DATA_W,
  parameter int CLK_DIV    = DAC_CLK_DIV,
  parameter int GAP_CYCLES = DAC_GAP_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              dac_cs_n,
  output logic              dac_sclk,
  output logic              dac_sdata,
  output logic              busy,
  output logic              done
);

  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam int GAP_W = cnt_width(GAP_CYCLES + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_t state, state_next;

  logic [DATA_W-1:0] hold_reg;
  logic              hold_full;
  // Only the bits still to be sent; the MSB goes straight to dac_sdata on load.
  logic [DATA_W-2:0] shift_reg;
  logic [BIT_W-1:0]  bit_cnt;
  logic [GAP_W-1:0]  gap_cnt;

  logic tick, phase;
  logic accept, load, sclk_rise, bit_end, last_bit;

  dac_bit_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_bit_timer (
    .clk  (clk),
    .reset(reset),
    .state(state),
    .tick (tick),
    .phase(phase)
  );

  // Handshake: a sample transfers on any posedge where in_valid && in_ready;
  // in_ready depends only on the holding register, never on in_valid.
  assign in_ready = !hold_full;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    sclk_rise  = 1'b0;
    bit_end    = 1'b0;
    last_bit   = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full) begin
          state_next = SHIFT;
          load       = 1'b1;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!phase) begin
            sclk_rise = 1'b1;
          end else begin
            bit_end = 1'b1;
            if (bit_cnt == BIT_LAST) begin
              last_bit   = 1'b1;
              state_next = GAP;
            end
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (hold_full) begin
            state_next = SHIFT;
            load       = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Load and accept never coincide: load needs hold_full, accept needs !hold_full.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_reg  <= '0;
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_reg  <= in;
      hold_full <= 1'b1;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || state != GAP || gap_cnt == GAP_LAST) gap_cnt <= '0;
    else                                             gap_cnt <= gap_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      dac_cs_n  <= 1'b1;
      dac_sclk  <= 1'b0;
      dac_sdata <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= last_bit;
      if (load) begin
        shift_reg <= hold_reg[DATA_W-2:0];
        bit_cnt   <= '0;
        dac_cs_n  <= 1'b0;
        dac_sclk  <= 1'b0;
        dac_sdata <= hold_reg[DATA_W-1];
      end else if (sclk_rise) begin
        dac_sclk <= 1'b1;
      end else if (bit_end) begin
        dac_sclk <= 1'b0;
        if (last_bit) begin
          bit_cnt   <= '0;
          dac_cs_n  <= 1'b1;
          dac_sdata <= 1'b0;
        end else begin
          bit_cnt   <= bit_cnt + 1'b1;
          dac_sdata <= shift_reg[DATA_W-2];
          shift_reg <= shift_reg << 1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dac_serializer.sv
// Directed bench: u0 uses default geometry, u1 uses CLK_DIV=1, GAP_CYCLES=1.
// A pin monitor records each frame; the directed steps compare those records.
module tb_dac_serializer;

  logic        clk;
  logic        reset;
  logic [15:0] in0, in1;
  logic        v0, v1;
  logic        rdy0, rdy1, cs0, cs1, sclk0, sclk1, sd0, sd1, busy0, busy1, done0, done1;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  dac_serializer u0 (
    .clk(clk), .reset(reset), .in(in0), .in_valid(v0), .in_ready(rdy0),
    .dac_cs_n(cs0), .dac_sclk(sclk0), .dac_sdata(sd0), .busy(busy0), .done(done0)
  );

  dac_serializer #(.DATA_W(16), .CLK_DIV(1), .GAP_CYCLES(1)) u1 (
    .clk(clk), .reset(reset), .in(in1), .in_valid(v1), .in_ready(rdy1),
    .dac_cs_n(cs1), .dac_sclk(sclk1), .dac_sdata(sd1), .busy(busy1), .done(done1)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // pin monitor: frame start, length, SCLK rises, bits sampled on rises
  logic m_cs[2], m_sclk[2], m_sd[2], m_done[2];
  assign m_cs[0] = cs0;     assign m_cs[1] = cs1;
  assign m_sclk[0] = sclk0; assign m_sclk[1] = sclk1;
  assign m_sd[0] = sd0;     assign m_sd[1] = sd1;
  assign m_done[0] = done0; assign m_done[1] = done1;

  logic        prev_cs[2] = '{1'b1, 1'b1};
  logic        prev_sclk[2] = '{1'b0, 1'b0};
  int          low_start[2], rises_cur[2], first_cur[2], sdhi_cur[2];
  logic [15:0] bits_cur[2];
  int          fr_start[2][16], fr_len[2][16], fr_rises[2][16], fr_first[2][16], fr_sdhi[2][16];
  logic [15:0] fr_bits[2][16];
  int          nfr[2] = '{0, 0};
  int          done_cyc[2][16];
  int          ndone[2] = '{0, 0};
  int          stray[2] = '{0, 0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (prev_cs[i] && !m_cs[i]) begin
        low_start[i] = cyc; rises_cur[i] = 0; first_cur[i] = -1;
        sdhi_cur[i] = 0;    bits_cur[i] = '0;
      end
      if (!m_cs[i]) begin
        if (m_sd[i]) sdhi_cur[i]++;
        if (!prev_sclk[i] && m_sclk[i]) begin
          if (rises_cur[i] == 0) first_cur[i] = cyc;
          bits_cur[i] = {bits_cur[i][14:0], m_sd[i]};
          rises_cur[i]++;
        end
      end else if (!prev_sclk[i] && m_sclk[i]) begin
        stray[i]++;
      end
      if (!prev_cs[i] && m_cs[i] && nfr[i] < 16) begin
        fr_start[i][nfr[i]] = low_start[i];
        fr_len[i][nfr[i]]   = cyc - low_start[i];
        fr_rises[i][nfr[i]] = rises_cur[i];
        fr_first[i][nfr[i]] = first_cur[i];
        fr_sdhi[i][nfr[i]]  = sdhi_cur[i];
        fr_bits[i][nfr[i]]  = bits_cur[i];
        nfr[i]++;
      end
      if (m_done[i] && ndone[i] < 16) begin
        done_cyc[i][ndone[i]] = cyc;
        ndone[i]++;
      end
      prev_cs[i]   = m_cs[i];
      prev_sclk[i] = m_sclk[i];
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_frames(input int i, input int target, input string tag);
    for (int k = 0; k < 400 && nfr[i] < target; k++) tick(1);
    check(tag, nfr[i], target);
  endtask

  int e0, f0, d0;

  initial begin
    reset = 1'b1;
    in0 = 16'hDEAD; v0 = 1'b1;
    in1 = 16'hBEEF; v1 = 1'b1;

    // reset held 3 cycles with in_valid high
    tick(3);
    check("rst_cs_n", cs0, 1'b1);
    check("rst_sclk", sclk0, 1'b0);
    check("rst_sdata", sd0, 1'b0);
    check("rst_in_ready", rdy0, 1'b1);
    check("rst_busy", busy0, 1'b0);
    check("rst_done", done0, 1'b0);
    check("rst_u1_cs_n", cs1, 1'b1);
    check("rst_u1_in_ready", rdy1, 1'b1);
    reset = 1'b0; v0 = 1'b0; v1 = 1'b0;
    tick(3);
    check("rst_nothing_captured", busy0, 1'b0);
    check("rst_nothing_captured_u1", busy1, 1'b0);

    // single frame A5C3
    f0 = nfr[0]; d0 = ndone[0];
    in0 = 16'hA5C3; v0 = 1'b1;
    tick(1); e0 = cyc; v0 = 1'b0;
    check("single_hold_full", rdy0, 1'b0);
    tick(1);
    check("single_cs_low", cs0, 1'b0);
    check("single_busy", busy0, 1'b1);
    check("single_ready_after_load", rdy0, 1'b1);
    wait_frames(0, f0 + 1, "single_frame_seen");
    tick(4);
    check("single_start", fr_start[0][f0], e0 + 1);
    check("single_len", fr_len[0][f0], 64);
    check("single_rises", fr_rises[0][f0], 16);
    check("single_first_rise", fr_first[0][f0], e0 + 3);
    check("single_bits", fr_bits[0][f0], 16'hA5C3);
    check("single_done_count", ndone[0], d0 + 1);
    check("single_done_cycle", done_cyc[0][d0], e0 + 65);
    check("single_idle_after", busy0, 1'b0);

    // back-to-back 0001 then FFFF, in_valid held high
    f0 = nfr[0]; d0 = ndone[0];
    in0 = 16'h0001; v0 = 1'b1;
    tick(1); e0 = cyc; in0 = 16'hFFFF;
    tick(1);
    check("b2b_ready_after_load", rdy0, 1'b1);
    tick(1);
    check("b2b_second_accepted", rdy0, 1'b0);
    v0 = 1'b0;
    wait_frames(0, f0 + 2, "b2b_frames_seen");
    tick(2);
    check("b2b_bits0", fr_bits[0][f0], 16'h0001);
    check("b2b_bits1", fr_bits[0][f0+1], 16'hFFFF);
    check("b2b_len1", fr_len[0][f0+1], 64);
    check("b2b_gap", fr_start[0][f0+1] - (fr_start[0][f0] + fr_len[0][f0]), 2);
    check("b2b_period", fr_start[0][f0+1] - fr_start[0][f0], 66);
    check("b2b_done0", done_cyc[0][d0], e0 + 65);
    check("b2b_done1", done_cyc[0][d0+1], e0 + 131);

    // backpressure: 1111 and 2222 offered while the holding register is full
    f0 = nfr[0];
    in0 = 16'h0F0F; v0 = 1'b1;
    tick(1); in0 = 16'h3C3C;
    tick(2);
    check("bp_hold_full", rdy0, 1'b0);
    in0 = 16'h1111;
    tick(5);
    check("bp_ready_low_1111", rdy0, 1'b0);
    in0 = 16'h2222;
    tick(5);
    check("bp_ready_low_2222", rdy0, 1'b0);
    for (int k = 0; k < 200 && !rdy0; k++) tick(1);
    check("bp_ready_returns", rdy0, 1'b1);
    tick(1);
    check("bp_2222_accepted", rdy0, 1'b0);
    v0 = 1'b0;
    wait_frames(0, f0 + 3, "bp_frames_seen");
    check("bp_bits0", fr_bits[0][f0], 16'h0F0F);
    check("bp_bits1", fr_bits[0][f0+1], 16'h3C3C);
    check("bp_bits2", fr_bits[0][f0+2], 16'h2222);
    tick(4);

    // reset after 8 bits of FF00, with BEEF waiting in the holding register
    f0 = nfr[0]; d0 = ndone[0];
    in0 = 16'hFF00; v0 = 1'b1;
    tick(1); in0 = 16'hBEEF;
    tick(2); v0 = 1'b0;
    check("abort_hold_full", rdy0, 1'b0);
    tick(31);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("abort_cs_n", cs0, 1'b1);
    check("abort_sclk", sclk0, 1'b0);
    check("abort_sdata", sd0, 1'b0);
    check("abort_in_ready", rdy0, 1'b1);
    tick(4);
    check("abort_hold_cleared", busy0, 1'b0);
    check("abort_frame_count", nfr[0], f0 + 1);
    check("abort_rises", fr_rises[0][f0], 8);
    check("abort_bits", fr_bits[0][f0], 16'h00FF);
    check("abort_no_done", ndone[0], d0);
    in0 = 16'h1234; v0 = 1'b1;
    tick(1); v0 = 1'b0;
    wait_frames(0, f0 + 2, "abort_next_frame_seen");
    check("abort_next_bits", fr_bits[0][f0+1], 16'h1234);
    check("abort_next_len", fr_len[0][f0+1], 64);
    check("abort_next_done", ndone[0], d0 + 1);

    // CLK_DIV=1, GAP_CYCLES=1: back-to-back 8000 frames
    f0 = nfr[1]; d0 = ndone[1];
    in1 = 16'h8000; v1 = 1'b1;
    tick(1); e0 = cyc;
    tick(2);
    check("div1_second_accepted", rdy1, 1'b0);
    v1 = 1'b0;
    wait_frames(1, f0 + 2, "div1_frames_seen");
    tick(2);
    check("div1_len", fr_len[1][f0], 32);
    check("div1_rises", fr_rises[1][f0], 16);
    check("div1_first_rise", fr_first[1][f0], e0 + 2);
    check("div1_bits", fr_bits[1][f0], 16'h8000);
    check("div1_sdata_high_cycles", fr_sdhi[1][f0], 2);
    check("div1_period", fr_start[1][f0+1] - fr_start[1][f0], 33);
    check("div1_done_cycle", done_cyc[1][d0], e0 + 33);
    check("div1_bits_second", fr_bits[1][f0+1], 16'h8000);

    check("no_sclk_outside_frame_u0", stray[0], 0);
    check("no_sclk_outside_frame_u1", stray[1], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dac_serializer.md
# dac_serializer

Transmit-side counterpart to the ADC sampling register. The block takes 16-bit parallel samples from the datapath over a valid/ready handshake, buffers one sample, and shifts each sample MSB-first to a serial DAC. The DAC link is SPI mode 0: chip-select active low, SCLK idle low, DAC samples SDATA on the rising SCLK edge. It sits between the processing core and the DAC pins.

## Interface
- DATA_W, 16, sample width and bits per frame
- CLK_DIV, 2, clk cycles per SCLK half-period (≥1)
- GAP_CYCLES, 2, minimum clk cycles with dac_cs_n high between frames (≥1)

Ports:
- clk  in  1  single system clock; all logic on posedge
- reset  in  1  synchronous, active-high
- in  in  DATA_W  sample to transmit; captured only on an accept edge
- in_valid  in  1  sample on `in` is valid
- in_ready  out  1  holding register empty; equals !hold_full, independent of in_valid
- dac_cs_n  out  1  frame select, active low
- dac_sclk  out  1  serial clock
- dac_sdata  out  1  serial data, MSB first
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse when a frame's last bit completes

## Operation
- Accept: in_valid && in_ready at a posedge. At that edge hold_reg<=in and hold_full<=1.
- FSM states, from package enum: IDLE, SHIFT, GAP.
- IDLE with hold_full=1 → SHIFT at the next edge. On that edge:
  - shift_reg<=hold_reg, hold_full<=0
  - dac_cs_n<=0, dac_sdata<=hold_reg[DATA_W-1], dac_sclk<=0
- SHIFT, per bit:
  - dac_sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - At the edge ending the high phase, shift_reg shifts left and dac_sdata takes the next bit.
  - dac_sdata is therefore stable for the whole high phase.
- After DATA_W bits → GAP. At that edge: dac_cs_n<=1, dac_sclk<=0, dac_sdata<=0, done<=1 for one cycle.
- GAP lasts GAP_CYCLES cycles. At exit:
  - hold_full=1 → SHIFT directly, with the same load as from IDLE.
  - otherwise → IDLE.
- While hold_full=1, in_ready=0 and changes on `in` are ignored.
- Underrun is not an error. The link idles with dac_cs_n high until the next sample arrives.
- Widths: bit counter is $clog2(DATA_W+1) bits; divider counter is $clog2(CLK_DIV) bits, minimum 1.

## Timing
- Reset values, one cycle after a reset edge:
  - dac_cs_n=1, dac_sclk=0, dac_sdata=0
  - in_ready=1 (hold_full=0), busy=0, done=0
  - state=IDLE, all counters 0
- Latency: accept at edge E0 from IDLE → dac_cs_n low after E1.
- First SCLK rising edge at E1+CLK_DIV.
- dac_cs_n high and done pulse after edge E1+2·DATA_W·CLK_DIV. With defaults: cs_n low for 64 cycles, done 65 cycles after E0.
- Back-to-back throughput: one frame per 2·DATA_W·CLK_DIV+GAP_CYCLES cycles, 66 with defaults.
- in_ready rises after the load edge, so the next sample can be accepted during SHIFT.
- Reset mid-frame takes priority over all other activity:
  - frame aborts; dac_cs_n high and dac_sclk low after the reset edge
  - hold register cleared, no done pulse
- Accept and reset at the same edge: reset wins and the sample is dropped.

## Structure
- Shared package dac_pkg holds:
  - state enum {IDLE, SHIFT, GAP}
  - default constants DAC_DATA_W=16, DAC_CLK_DIV=2, DAC_GAP_CYCLES=2
- One sub-module, dac_bit_timer:
  - divider counter producing half-period tick and phase outputs
  - cleared on reset and whenever state ≠ SHIFT
- Top level contains the holding register, shift register, bit counter, FSM and registered outputs.
- All pin outputs are driven directly from flops, with no combinational path to pins.

## Test plan
- Reset: hold reset 3 cycles with in_valid=1 → dac_cs_n=1, dac_sclk=0, dac_sdata=0, in_ready=1, busy=0, done=0; nothing captured.
- Single frame, defaults, in=16'hA5C3:
  - dac_cs_n low from E0+1 for 64 cycles
  - exactly 16 SCLK rising edges; bits sampled there = 1010_0101_1100_0011
  - done pulse at E0+65
- Back-to-back 16'h0001 then 16'hFFFF, in_valid held high:
  - second sample accepted the cycle after the first load
  - dac_cs_n high exactly 2 cycles between frames; frame period 66
- Backpressure: while hold_full, present 16'h1111 then 16'h2222 → in_ready=0 and nothing captured; the value present at the accept edge (16'h2222) is transmitted.
- Reset after 8 bits of 16'hFF00:
  - dac_cs_n=1 and dac_sclk=0 after the reset edge; no done pulse
  - next sample 16'h1234 transmits intact
- CLK_DIV=1, GAP_CYCLES=1, in=16'h8000:
  - SCLK toggles every cycle; dac_cs_n low for 32 cycles; back-to-back period 33
  - dac_sdata=1 only during bit 0
